// File: rtl/ex_pkg.sv
// Shared definitions for the execute/write-back stage: datapath width,
// opcode values and the sequencing state encoding.
package ex_pkg;

  localparam int unsigned WORD_SIZE = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_TCP = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ADI = 4'd8;
  localparam logic [3:0] OP_LHI = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational single-cycle ALU. MUL and the NOP opcodes report no write;
// the iterative multiply is sequenced by the enclosing stage.
module ex_alu
  import ex_pkg::*;
(
  input  logic [3:0]           op_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [7:0]           imm_i,
  output logic [WORD_SIZE-1:0] result_o,
  output logic                 wr_o,
  output logic                 ovf_upd_o,
  output logic                 ovf_o
);

  logic [WORD_SIZE-1:0] imm_sext;

  assign imm_sext = {{(WORD_SIZE-8){imm_i[7]}}, imm_i};

  // Signed overflow: operands agree in sign (after negating b for SUB) but
  // the result's sign does not.
  always_comb begin
    result_o  = '0;
    wr_o      = 1'b1;
    ovf_upd_o = 1'b0;
    ovf_o     = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o  = a_i + b_i;
        ovf_upd_o = 1'b1;
        ovf_o     = (a_i[WORD_SIZE-1] == b_i[WORD_SIZE-1]) &&
                    (result_o[WORD_SIZE-1] != a_i[WORD_SIZE-1]);
      end
      OP_SUB: begin
        result_o  = a_i - b_i;
        ovf_upd_o = 1'b1;
        ovf_o     = (a_i[WORD_SIZE-1] != b_i[WORD_SIZE-1]) &&
                    (result_o[WORD_SIZE-1] != a_i[WORD_SIZE-1]);
      end
      OP_ADI: begin
        result_o  = a_i + imm_sext;
        ovf_upd_o = 1'b1;
        ovf_o     = (a_i[WORD_SIZE-1] == imm_sext[WORD_SIZE-1]) &&
                    (result_o[WORD_SIZE-1] != a_i[WORD_SIZE-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_ORR:  result_o = a_i | b_i;
      OP_NOT:  result_o = ~a_i;
      OP_TCP:  result_o = '0 - a_i;
      OP_SHL:  result_o = a_i << 1;
      OP_SHR:  result_o = a_i >> 1;
      OP_LHI:  result_o = {imm_i, {(WORD_SIZE-8){1'b0}}};
      default: wr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/write-back stage in front of the register file: single-cycle ALU ops,
// an iterative shift-add MUL, and forwarding from the registered write-back.
module ex_wb_stage
  import ex_pkg::*;
#(
  parameter int unsigned NUM_REG    = 4,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [$clog2(NUM_REG)-1:0] in_rs1,
  input  logic [$clog2(NUM_REG)-1:0] in_rs2,
  input  logic [$clog2(NUM_REG)-1:0] in_rd,
  input  logic [7:0]                 in_imm,
  output logic [$clog2(NUM_REG)-1:0] rf_addr1,
  output logic [$clog2(NUM_REG)-1:0] rf_addr2,
  input  logic [WORD_SIZE-1:0]       rf_data1,
  input  logic [WORD_SIZE-1:0]       rf_data2,
  output logic                       rf_write,
  output logic [$clog2(NUM_REG)-1:0] rf_addr3,
  output logic [WORD_SIZE-1:0]       rf_data3,
  output logic                       ovf
);

  localparam int unsigned AW = $clog2(NUM_REG);
  localparam int unsigned CW = $clog2(MUL_CYCLES);

  state_t               state_q;
  logic [AW-1:0]        rs1_q, rs2_q, mul_rd_q;
  logic [WORD_SIZE-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CW-1:0]        cnt_q;
  logic                 wb_valid_q;
  logic [AW-1:0]        wb_rd_q;
  logic [WORD_SIZE-1:0] wb_result_q;
  logic                 ovf_q;

  logic [WORD_SIZE-1:0] op_a, op_b, alu_res;
  logic                 alu_wr, alu_ovf_upd, alu_ovf;
  logic                 accept;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  assign rf_addr1 = (state_q == ST_IDLE) ? in_rs1 : rs1_q;
  assign rf_addr2 = (state_q == ST_IDLE) ? in_rs2 : rs2_q;

  // The RF only commits at the end of the write-back cycle, so a pending
  // result must bypass the stale read data.
  assign op_a = (wb_valid_q && wb_rd_q == rf_addr1) ? wb_result_q : rf_data1;
  assign op_b = (wb_valid_q && wb_rd_q == rf_addr2) ? wb_result_q : rf_data2;

  assign acc_d = mplier_q[cnt_q] ? acc_q + (mcand_q << cnt_q) : acc_q;

  assign rf_write = wb_valid_q;
  assign rf_addr3 = wb_rd_q;
  assign rf_data3 = wb_result_q;
  assign ovf      = ovf_q;

  ex_alu u_alu (
    .op_i      (in_op),
    .a_i       (op_a),
    .b_i       (op_b),
    .imm_i     (in_imm),
    .result_o  (alu_res),
    .wr_o      (alu_wr),
    .ovf_upd_o (alu_ovf_upd),
    .ovf_o     (alu_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      mul_rd_q    <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_result_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_op == OP_MUL) begin
              rs1_q    <= in_rs1;
              rs2_q    <= in_rs2;
              mul_rd_q <= in_rd;
              mcand_q  <= op_a;
              mplier_q <= op_b;
              cnt_q    <= '0;
              acc_q    <= '0;
              state_q  <= ST_MUL;
            end else if (alu_wr) begin
              wb_valid_q  <= 1'b1;
              wb_rd_q     <= in_rd;
              wb_result_q <= alu_res;
              if (alu_ovf_upd) ovf_q <= alu_ovf;
            end
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(MUL_CYCLES - 1)) begin
            wb_valid_q  <= 1'b1;
            wb_rd_q     <= mul_rd_q;
            wb_result_q <= acc_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: behavioural register-file environment, an
// architectural reference model feeding a write-back scoreboard, and directed
// plus random instruction streams.
module tb_ex_wb_stage;
  import ex_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [1:0]  in_rs1, in_rs2, in_rd;
  logic [7:0]  in_imm;
  logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
  logic [15:0] rf_data1, rf_data2, rf_data3;
  logic        rf_write;
  logic        ovf;

  ex_wb_stage #(.NUM_REG(4), .MUL_CYCLES(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_rd    (in_rd),
    .in_imm   (in_imm),
    .rf_addr1 (rf_addr1),
    .rf_addr2 (rf_addr2),
    .rf_data1 (rf_data1),
    .rf_data2 (rf_data2),
    .rf_write (rf_write),
    .rf_addr3 (rf_addr3),
    .rf_data3 (rf_data3),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the stage: combinational read, write on the edge.
  logic [15:0] env_rf [4] = '{default: '0};
  assign rf_data1 = env_rf[rf_addr1];
  assign rf_data2 = env_rf[rf_addr2];
  always @(posedge clk) if (rf_write) env_rf[rf_addr3] <= rf_data3;

  typedef struct {
    logic [1:0]  rd;
    logic [15:0] data;
    bit          ovf;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [15:0] m_rf [4] = '{default: '0};
  bit          m_ovf;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] snap [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural semantics in plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] imm, output logic [15:0] r, output bit wr,
                                output bit ovf_upd, output bit ovf_v);
    int s, sa, sb, si;
    sa = $signed(a);
    sb = $signed(b);
    si = $signed(imm);
    s = 0;
    r = '0;
    wr = 1'b1;
    ovf_upd = 1'b0;
    ovf_v = 1'b0;
    case (op)
      OP_ADD: begin s = sa + sb; ovf_upd = 1'b1; end
      OP_SUB: begin s = sa - sb; ovf_upd = 1'b1; end
      OP_ADI: begin s = sa + si; ovf_upd = 1'b1; end
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_NOT: r = 16'hFFFF - a;
      OP_TCP: r = 16'(0 - int'(a));
      OP_SHL: r = 16'(int'(a) * 2);
      OP_SHR: r = a / 16'd2;
      OP_LHI: r = 16'(int'(imm) * 256);
      OP_MUL: r = 16'(longint'(a) * longint'(b));
      default: wr = 1'b0;
    endcase
    if (ovf_upd) begin
      r = 16'(s);
      ovf_v = (s > 32767) || (s < -32768);
    end
  endfunction

  // Presents one instruction and returns 1ns after the edge that accepts it.
  task automatic issue(input logic [3:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [1:0] rd, input logic [7:0] imm, input bit track);
    int unsigned guard;
    logic [15:0] r;
    bit wr, ou, ov;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) check("issue_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_op = op;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_rd = rd;
    in_imm = imm;
    if (track) begin
      model(op, m_rf[rs1], m_rf[rs2], imm, r, wr, ou, ov);
      if (ou) m_ovf = ov;
      if (wr) begin
        m_rf[rd] = r;
        e.rd = rd;
        e.data = r;
        e.ovf = m_ovf;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rf_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got write r%0d=%h expected none (t=%0t)", rf_addr3, rf_data3, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_addr", rf_addr3, mon_e.rd);
        check("wb_data", rf_data3, mon_e.data);
        check("wb_ovf", ovf, mon_e.ovf);
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_op = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_rd = '0;
    in_imm = '0;
    m_ovf = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_write", rf_write, 0);
    check("reset_addr3", rf_addr3, 0);
    check("reset_data3", rf_data3, 0);
    check("reset_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Dependent back-to-back pair relying on forwarding.
    issue(OP_LHI, 2'd0, 2'd0, 2'd0, 8'h52, 1);
    issue(OP_ADI, 2'd0, 2'd0, 2'd1, 8'hFF, 1);
    drain();
    check("rf_r0_lhi", env_rf[0], 16'h5200);
    check("rf_r1_adi", env_rf[1], 16'h51FF);

    issue(OP_LHI, 2'd0, 2'd0, 2'd1, 8'h40, 1);
    issue(OP_ADD, 2'd1, 2'd1, 2'd2, 8'h00, 1);
    issue(OP_SUB, 2'd2, 2'd2, 2'd3, 8'h00, 1);
    drain();
    check("rf_r2_add_ovf", env_rf[2], 16'h8000);
    check("rf_r3_sub", env_rf[3], 16'h0000);

    // MUL latency and busy window.
    issue(OP_LHI, 2'd0, 2'd0, 2'd0, 8'h00, 1);
    issue(OP_ADI, 2'd0, 2'd0, 2'd0, 8'h03, 1);
    issue(OP_LHI, 2'd0, 2'd0, 2'd1, 8'h12, 1);
    issue(OP_ADI, 2'd1, 2'd0, 2'd1, 8'h34, 1);
    issue(OP_MUL, 2'd0, 2'd1, 2'd3, 8'h00, 1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        check("mul_busy_ready", in_ready, 0);
        check("mul_busy_write", rf_write, 0);
      end else begin
        check("mul_done_write", rf_write, 1);
        check("mul_done_data", rf_data3, 16'h369C);
        check("mul_done_ready", in_ready, 1);
      end
    end
    drain();
    check("rf_r3_mul", env_rf[3], 16'h369C);

    // Reset in the middle of a multiply: no write must escape.
    issue(OP_MUL, 2'd1, 2'd1, 2'd3, 8'h00, 0);
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    m_ovf = 1'b0;
    #1;
    check("mulabort_write", rf_write, 0);
    check("mulabort_ready", in_ready, 1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mulabort_r3_kept", env_rf[3], 16'h369C);

    // Reset landing on a pending write-back clears it before it commits.
    issue(OP_LHI, 2'd0, 2'd0, 2'd2, 8'h80, 1);
    issue(OP_ADI, 2'd2, 2'd0, 2'd2, 8'hFF, 0);
    check("pend_write", rf_write, 1);
    check("pend_addr3", rf_addr3, 2);
    check("pend_data3", rf_data3, 16'h7FFF);
    check("pend_ovf", ovf, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_write", rf_write, 0);
    check("async_addr3", rf_addr3, 0);
    check("async_data3", rf_data3, 0);
    check("async_ovf", ovf, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    drain();
    check("pend_r2_kept", env_rf[2], 16'h8000);

    // Idle cycles and a NOP leave the register file alone.
    for (int i = 0; i < 4; i++) snap[i] = env_rf[i];
    repeat (3) begin
      @(negedge clk);
      check("idle_write", rf_write, 0);
    end
    issue(4'hF, 2'd1, 2'd2, 2'd3, 8'hAA, 1);
    @(negedge clk);
    check("nop_write", rf_write, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check("nop_rf_unchanged", env_rf[i], snap[i]);

    // Same destination twice, then a consumer of it.
    issue(OP_LHI, 2'd0, 2'd0, 2'd2, 8'h11, 1);
    issue(OP_LHI, 2'd0, 2'd0, 2'd2, 8'h22, 1);
    issue(OP_ADD, 2'd2, 2'd2, 2'd0, 8'h00, 1);
    drain();
    check("last_write_wins", env_rf[0], 16'h4400);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1);
    end
    drain();
    for (int i = 0; i < 4; i++) check("final_rf", env_rf[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
